gelato_wb_arbiter: RTL and testbench
====================================

# gelato_wb_arbiter

Round-robin arbiter that shares the single vector register-file writeback port among `REQ_NUM` producers (compute scheduler, load/store unit, special-function unit, ...). Each producer presents one warp-wide writeback per valid/ready handshake. The arbiter grants at most one producer per cycle and drives a registered writeback to the register file. Writes to `x0` and writes with an all-zero thread mask are accepted and then discarded.

## Interface
- `REQ_NUM`, 4: number of writeback requesters; must be ≥2.
- `THREAD_NUM`, 32: threads per warp.
- `DATA_WIDTH`, 32: bits per thread lane.
- `REG_ADDR_WIDTH`, 5: destination register index width.
- `WARP_ID_WIDTH`, 5: warp identifier width.
- Reset `rst_n` is asynchronous and active-low; the clock is `clk`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rdy`  in  1  global enable; when low, no grants and no state change except `wb_valid` clearing.
- `req_valid`  in  REQ_NUM  per-requester request.
- `req_ready`  out  REQ_NUM  per-requester grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `req_warp`  in  REQ_NUM×WARP_ID_WIDTH  warp id per requester.
- `req_rd`  in  REQ_NUM×REG_ADDR_WIDTH  destination register per requester.
- `req_mask`  in  REQ_NUM×THREAD_NUM  active-thread mask per requester.
- `req_data`  in  REQ_NUM×THREAD_NUM×DATA_WIDTH  lane data per requester.
- `wb_valid`  out  1  register-file write strobe, one cycle per accepted write.
- `wb_warp`  out  WARP_ID_WIDTH  warp id of the write.
- `wb_rd`  out  REG_ADDR_WIDTH  destination register.
- `wb_mask`  out  THREAD_NUM  per-lane write enable.
- `wb_data`  out  THREAD_NUM×DATA_WIDTH  lane data.
- `grant_idx`  out  $clog2(REQ_NUM)  index of the requester behind the current `wb_valid`; for debug and scoreboard release.

## Operation
- The priority pointer `last` holds the most recently granted index. The search order is `last+1, last+2, …, last`, modulo `REQ_NUM`, and wraps from `REQ_NUM-1` to 0.
- `req_ready` is combinational. Exactly one bit is high: the first valid requester in search order, and only when `rdy=1`. All bits are 0 when no request is valid or `rdy=0`.
- `req_ready[i]` may depend on `req_valid`. A requester must not make `req_valid` depend on `req_ready`. It must hold `req_valid` and its payload stable until the transfer.
- On a transfer, `last` is set to the granted index and the payload is captured into the output registers.
- **Discard rule:** if the captured `rd==0` or `mask==0`, the request is accepted (ready is high), `wb_valid` stays 0, and the pointer still advances.
- Otherwise `wb_valid=1` for exactly one cycle. The other `wb_*` fields and `grant_idx` are written alongside. Payload fields keep their last value when `wb_valid=0`.
- The register file always accepts, so there is no backpressure on the `wb_*` side.
- There is no FSM beyond the pointer. Steady-state throughput is one write per cycle.
- Reset: `last=REQ_NUM-1`, so requester 0 has first priority. `wb_valid=0`, `wb_warp=0`, `wb_rd=0`, `wb_mask=0`, `wb_data=0`, `grant_idx=0`.
- Reset asserted mid-stream aborts any in-flight write. A write captured in the cycle before reset does not appear after reset.

## Timing
- Request to grant: 0 cycles (combinational `req_ready`).
- Transfer edge to `wb_valid`: 1 cycle (registered output).
- With `rdy=0`, `wb_valid` is 0 on the next edge and the pointer holds. Pending requests wait; none are lost.
- If all `REQ_NUM` requesters stay valid, each is granted exactly once every `REQ_NUM` cycles. Maximum wait is `REQ_NUM-1` cycles.
- A requester that drops `req_valid` before being granted (a protocol violation) is simply skipped. It does not affect the pointer.

## Structure
- Add `wb_req_t` (warp, rd, mask, data) to package `gelato_types`. Derive its widths from `THREAD_NUM`, `DATA_WIDTH`, `REG_ADDR_WIDTH` and `WARP_ID_WIDTH`. Request and output buses use this type.
- Sub-module `gelato_rr_arbiter` (parameter `N`) computes the one-hot grant from `req`, `last` and `en`, and returns the grant index. It is reused later for the issue and memory-port arbiters.
- The top level holds the `last` register, the payload mux, the discard check and the output registers.

## Test plan
- After reset, `req_valid=4'b1111` held for 8 cycles with `rdy=1` → grants in order 0,1,2,3,0,1,2,3; `wb_valid` high for 8 consecutive cycles starting 1 cycle after the first grant.
- Only requester 2 valid (warp=3, rd=7, mask=32'hFFFF_0000, lane data = lane index) → `req_ready=4'b0100` the same cycle; next cycle `wb_valid=1`, `wb_warp=3`, `wb_rd=7`, `wb_mask=32'hFFFF_0000`, `grant_idx=2`.
- Requester 1 with `rd=0`, then requester 1 with `mask=0` → both accepted; `wb_valid` stays 0 both times; the pointer advances, so a simultaneous request from requester 0 is granted on the following cycle.
- Requesters 0 and 3 valid, `rdy` held low for 3 cycles, then high → `req_ready=0` and `wb_valid=0` throughout; after `rdy` rises, requester 0 is granted and then requester 3.
- `last=3` with requesters 0 and 3 valid → requester 0 is granted (wrap-around), then requester 3.
- Assert `rst_n` low in the cycle after a grant → all `wb_*` outputs read 0, `last=3`, and the aborted write never appears.

Source files
------------

// File: rtl/gelato_types.sv
// rtl/gelato_types.sv - shared GPU core types: warp writeback payload
//
// Purpose: shared widths and the writeback payload struct used by the
//          writeback arbiter and the register-file port.
// Ports:   none (package).
package gelato_types;

  localparam int GT_THREAD_NUM     = 32;
  localparam int GT_DATA_WIDTH     = 32;
  localparam int GT_REG_ADDR_WIDTH = 5;
  localparam int GT_WARP_ID_WIDTH  = 5;

  typedef struct packed {
    logic [GT_WARP_ID_WIDTH-1:0]                  warp;
    logic [GT_REG_ADDR_WIDTH-1:0]                 rd;
    logic [GT_THREAD_NUM-1:0]                     mask;
    logic [GT_THREAD_NUM-1:0][GT_DATA_WIDTH-1:0]  data;
  } wb_req_t;

  // x0 is hardwired zero and an empty mask writes no lane: such writes are
  // accepted from the producer but never reach the register file.
  function automatic logic wb_is_discard(input wb_req_t r);
    return (r.rd == '0) || (r.mask == '0);
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// rtl/gelato_rr_arbiter.sv - combinational round-robin grant picker
//
// Purpose: picks the first asserted request searching last+1, last+2, ...,
//          last (mod N). Holds no state; the caller owns the pointer.
// Ports:
//   req         in  N     request vector
//   last        in  IW    most recently granted index
//   en          in  1     when low no grant is issued
//   grant       out N     one-hot grant (all zero if none)
//   grant_idx   out IW    index of the granted request
//   grant_valid out 1     a grant was issued
module gelato_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] w_pos;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_pos       = '0;
    // k runs to N so that "last" itself is searched last.
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(last) + k) % N);
      if (en && !grant_valid && req[w_pos]) begin
        grant[w_pos] = 1'b1;
        grant_idx    = w_pos;
        grant_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_wb_arbiter.sv
// rtl/gelato_wb_arbiter.sv - round-robin arbiter for the register-file writeback port
//
// Purpose: shares the single vector register-file write port among REQ_NUM
//          producers, one valid/ready transfer per cycle, registered output.
//          THREAD_NUM/DATA_WIDTH/REG_ADDR_WIDTH/WARP_ID_WIDTH must match the
//          widths in gelato_types since the payload is carried as wb_req_t.
// Ports:
//   clk, rst_n  in   clock, asynchronous active-low reset
//   rdy         in   global enable; low blocks grants
//   req_valid   in   per-requester request
//   req_ready   out  per-requester grant (combinational)
//   req_warp/rd/mask/data  in  per-requester payload
//   wb_valid    out  register-file write strobe
//   wb_warp/rd/mask/data   out registered write payload
//   grant_idx   out  requester behind the current wb_valid
module gelato_wb_arbiter
  import gelato_types::*;
#(
  parameter int REQ_NUM        = 4,
  parameter int THREAD_NUM     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WARP_ID_WIDTH  = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          rdy,
  input  logic [REQ_NUM-1:0]                            req_valid,
  output logic [REQ_NUM-1:0]                            req_ready,
  input  logic [REQ_NUM-1:0][WARP_ID_WIDTH-1:0]         req_warp,
  input  logic [REQ_NUM-1:0][REG_ADDR_WIDTH-1:0]        req_rd,
  input  logic [REQ_NUM-1:0][THREAD_NUM-1:0]            req_mask,
  input  logic [REQ_NUM-1:0][THREAD_NUM-1:0][DATA_WIDTH-1:0] req_data,
  output logic                                          wb_valid,
  output logic [WARP_ID_WIDTH-1:0]                      wb_warp,
  output logic [REG_ADDR_WIDTH-1:0]                     wb_rd,
  output logic [THREAD_NUM-1:0]                         wb_mask,
  output logic [THREAD_NUM-1:0][DATA_WIDTH-1:0]         wb_data,
  output logic [$clog2(REQ_NUM)-1:0]                    grant_idx
);

  localparam int IDX_W = $clog2(REQ_NUM);

  wb_req_t    w_req [REQ_NUM];
  wb_req_t    w_sel;
  logic [IDX_W-1:0] w_idx;
  logic       w_any;

  logic [IDX_W-1:0] r_last;
  logic       r_wb_valid;
  wb_req_t    r_wb;
  logic [IDX_W-1:0] r_grant_idx;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      w_req[i].warp = req_warp[i];
      w_req[i].rd   = req_rd[i];
      w_req[i].mask = req_mask[i];
      w_req[i].data = req_data[i];
    end
  end

  gelato_rr_arbiter #(
    .N  (REQ_NUM),
    .IW (IDX_W)
  ) u_rr (
    .req         (req_valid),
    .last        (r_last),
    .en          (rdy),
    .grant       (req_ready),
    .grant_idx   (w_idx),
    .grant_valid (w_any)
  );

  assign w_sel = w_req[w_idx];

  // The pointer advances on every transfer, discarded ones included, so a
  // stream of x0/empty-mask writes cannot starve the other producers.
  // Payload registers only load on real writes and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= IDX_W'(REQ_NUM - 1);
      r_wb_valid  <= 1'b0;
      r_wb        <= '0;
      r_grant_idx <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_any) begin
        r_last <= w_idx;
        if (!wb_is_discard(w_sel)) begin
          r_wb_valid  <= 1'b1;
          r_wb        <= w_sel;
          r_grant_idx <= w_idx;
        end
      end
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_warp   = r_wb.warp;
  assign wb_rd     = r_wb.rd;
  assign wb_mask   = r_wb.mask;
  assign wb_data   = r_wb.data;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// tb/tb_gelato_wb_arbiter.sv - self-checking bench for gelato_wb_arbiter
module tb_gelato_wb_arbiter;

  localparam int N = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     rdy = 1'b0;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0]             req_ready;
  logic [N-1:0][4:0]        req_warp = '0;
  logic [N-1:0][4:0]        req_rd = '0;
  logic [N-1:0][31:0]       req_mask = '0;
  logic [N-1:0][31:0][31:0] req_data = '0;
  logic                     wb_valid;
  logic [4:0]               wb_warp;
  logic [4:0]               wb_rd;
  logic [31:0]              wb_mask;
  logic [31:0][31:0]        wb_data;
  logic [1:0]               grant_idx;

  gelato_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_warp(req_warp), .req_rd(req_rd), .req_mask(req_mask), .req_data(req_data),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_rd(wb_rd), .wb_mask(wb_mask),
    .wb_data(wb_data), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointer and expected register-file write.
  int               m_last;
  int               m_grant;
  logic             m_wv;
  logic [4:0]       m_warp, m_rd;
  logic [31:0]      m_mask;
  logic [31:0][31:0] m_data;
  int               m_gi;
  logic [N-1:0]     s_ready;

  task automatic model_reset();
    m_last = N - 1; m_grant = -1; m_wv = 1'b0;
    m_warp = '0; m_rd = '0; m_mask = '0; m_data = '0; m_gi = 0;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last, input logic en);
    if (!en) return -1;
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [31:0][31:0] exp);
    int bad;
    bad = -1;
    for (int l = 0; l < 32; l++)
      if (bad < 0 && wb_data[l] !== exp[l]) bad = l;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: lane %0d got %h expected %h", name, bad, wb_data[bad], exp[bad]);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " wb_valid"}, 64'(wb_valid), 64'(m_wv));
    chk({tag, " grant_idx"}, 64'(grant_idx), 64'(m_gi));
    chk({tag, " wb_warp"}, 64'(wb_warp), 64'(m_warp));
    chk({tag, " wb_rd"}, 64'(wb_rd), 64'(m_rd));
    chk({tag, " wb_mask"}, 64'(wb_mask), 64'(m_mask));
    chk_data({tag, " wb_data"}, m_data);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick(input string tag);
    logic [N-1:0] exp_ready;
    #1;
    m_grant   = pick(req_valid, m_last, rdy);
    exp_ready = (m_grant >= 0) ? (N'(1) << m_grant) : '0;
    s_ready   = req_ready;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    m_wv = 1'b0;
    if (m_grant >= 0) begin
      m_last = m_grant;
      if (req_rd[m_grant] != 0 && req_mask[m_grant] != 0) begin
        m_wv   = 1'b1;
        m_warp = req_warp[m_grant];
        m_rd   = req_rd[m_grant];
        m_mask = req_mask[m_grant];
        m_data = req_data[m_grant];
        m_gi   = m_grant;
      end
    end
    @(negedge clk);
    chk_outputs(tag);
  endtask

  typedef struct {
    logic         rdy;
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    logic         exp_wv;
    int           exp_gi;
  } vec_t;

  vec_t tbl[14];
  logic [N-1:0] pending;

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010, 1'b1, 1};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 2};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 3};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0001, 1'b1, 0};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0010, 1'b1, 1};
    tbl[6]  = '{1'b1, 4'b1111, 4'b0100, 1'b1, 2};
    tbl[7]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 3};
    tbl[8]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 3};
    tbl[9]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 3};
    tbl[10] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 3};
    tbl[11] = '{1'b1, 4'b1001, 4'b0001, 1'b1, 0};
    tbl[12] = '{1'b1, 4'b1001, 4'b1000, 1'b1, 3};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 3};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset wb_valid", 64'(wb_valid), 64'(0));
    chk("reset grant_idx", 64'(grant_idx), 64'(0));
    chk("reset wb_warp", 64'(wb_warp), 64'(0));
    chk("reset wb_rd", 64'(wb_rd), 64'(0));
    chk("reset wb_mask", 64'(wb_mask), 64'(0));
    chk_data("reset wb_data", '0);
    rst_n = 1'b1;

    // Table phase: every requester carries a real write.
    for (int i = 0; i < N; i++) begin
      req_warp[i] = 5'(i + 8);
      req_rd[i]   = 5'(i + 1);
      req_mask[i] = 32'hFFFF_FFFF;
      for (int l = 0; l < 32; l++) req_data[i][l] = $urandom;
    end
    for (int t = 0; t < 14; t++) begin
      rdy = tbl[t].rdy;
      req_valid = tbl[t].valid;
      tick($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d ready", t), 64'(s_ready), 64'(tbl[t].exp_ready));
      chk($sformatf("tbl%0d wb_valid", t), 64'(wb_valid), 64'(tbl[t].exp_wv));
      chk($sformatf("tbl%0d grant_idx", t), 64'(grant_idx), 64'(tbl[t].exp_gi));
    end

    // Single requester 2 with lane data = lane index.
    req_warp[2] = 5'd3; req_rd[2] = 5'd7; req_mask[2] = 32'hFFFF_0000;
    for (int l = 0; l < 32; l++) req_data[2][l] = 32'(l);
    req_valid = 4'b0100;
    tick("req2");
    chk("req2 ready", 64'(s_ready), 64'(4'b0100));
    chk("req2 wb_valid", 64'(wb_valid), 64'(1));
    chk("req2 wb_warp", 64'(wb_warp), 64'(3));
    chk("req2 wb_rd", 64'(wb_rd), 64'(7));
    chk("req2 wb_mask", 64'(wb_mask), 64'(32'hFFFF_0000));
    chk("req2 grant_idx", 64'(grant_idx), 64'(2));
    chk("req2 lane31", 64'(wb_data[31]), 64'(31));

    // Discard rule: pointer advances past discarded writes.
    req_valid = 4'b0001;
    tick("d_pre");
    req_rd[1] = 5'd0; req_mask[1] = 32'h0000_00FF;
    req_valid = 4'b0011;
    tick("d_rd0");
    chk("d_rd0 ready", 64'(s_ready), 64'(4'b0010));
    chk("d_rd0 wb_valid", 64'(wb_valid), 64'(0));
    req_rd[1] = 5'd5; req_mask[1] = 32'h0;
    tick("d_adv");
    chk("d_adv ready", 64'(s_ready), 64'(4'b0001));
    chk("d_adv wb_valid", 64'(wb_valid), 64'(1));
    chk("d_adv grant_idx", 64'(grant_idx), 64'(0));
    req_valid = 4'b0010;
    tick("d_m0");
    chk("d_m0 ready", 64'(s_ready), 64'(4'b0010));
    chk("d_m0 wb_valid", 64'(wb_valid), 64'(0));
    req_mask[1] = 32'h1;
    req_valid = 4'b0011;
    tick("d_post");
    chk("d_post ready", 64'(s_ready), 64'(4'b0001));

    // Reset right after a grant edge aborts the captured write.
    req_valid = 4'b0100;
    #1;
    chk("abort ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("abort");
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick("after_rst0");
    tick("after_rst1");
    chk("after_rst wb_valid", 64'(wb_valid), 64'(0));
    req_valid = 4'b1001;
    tick("after_rst2");
    chk("after_rst last=3 ready", 64'(s_ready), 64'(4'b0001));
    req_valid = 4'b0000;
    tick("after_rst3");

    // Randomized protocol-respecting traffic.
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i]  = 1'b1;
          req_warp[i] = 5'($urandom);
          req_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          req_mask[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
          for (int l = 0; l < 32; l++) req_data[i][l] = $urandom;
        end
      end
      req_valid = pending;
      rdy = ($urandom_range(0, 9) != 0);
      tick($sformatf("rnd%0d", c));
      if (m_grant >= 0) pending[m_grant] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
